// File: rtl/exc_request_ctrl.sv
// Exception/interrupt requester for CP0: decodes trap events and latches interrupt edges.
// It arbitrates these requests and sequences the CP0 entry/return strobes, the fetch redirect and the pipeline flush.
module exc_request_ctrl #(
    parameter int unsigned INT_W      = 4,
    parameter int unsigned FLUSH_CYC  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             ins_syscall,
    input  logic             ins_break,
    input  logic             ins_teq,
    input  logic             teq_equal,
    input  logic             ins_eret,
    input  logic [INT_W-1:0] int_req,
    input  logic [31:0]      status,
    input  logic [31:0]      pc_cur,
    output logic [1:0]       exc_signal,
    output logic [3:0]       cause,
    output logic [31:0]      exc_pc,
    output logic [31:0]      redirect_pc,
    output logic             redirect,
    output logic             pipe_flush,
    output logic             in_handler,
    output logic [INT_W-1:0] int_ack,
    output logic [7:0]       dropped_cnt
);

    typedef enum logic [2:0] {IDLE, RAISE, FLUSH, HANDLER, RETURN} state_t;

    state_t           state_q, state_n;
    logic [3:0]       flush_cnt_q;
    logic [INT_W-1:0] pending_q, int_req_q, int_rise, int_onehot, ack_n;
    logic             sys_qual, brk_qual, teq_qual, int_qual, trap_qual, int_win, take;
    logic [3:0]       code_n;
    logic [1:0]       exc_signal_n;
    logic [31:0]      redirect_pc_n;
    logic             redirect_n, pipe_flush_n, in_handler_n;
    logic             unused_status;

    assign unused_status = ^status[31:5];

    assign sys_qual   = ins_syscall & status[0] & status[1];
    assign brk_qual   = ins_break & status[0] & status[2];
    assign teq_qual   = ins_teq & teq_equal & status[0] & status[3];
    assign int_qual   = (|pending_q) & status[0] & status[4];
    assign trap_qual  = sys_qual | brk_qual | teq_qual;
    assign int_win    = int_qual & ~trap_qual;
    assign take       = (state_q == IDLE) & (trap_qual | int_qual);
    assign int_rise   = int_req & ~int_req_q;
    // Isolate the lowest set pending bit.
    assign int_onehot = pending_q & (~pending_q + INT_W'(1));
    assign ack_n      = (take && int_win) ? int_onehot : '0;

    always_comb begin
        code_n = 4'd0;
        if (sys_qual)      code_n = 4'd8;
        else if (brk_qual) code_n = 4'd9;
        else if (teq_qual) code_n = 4'd13;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (take) state_n = RAISE;
            RAISE:   state_n = (FLUSH_CYC > 1) ? FLUSH : HANDLER;
            FLUSH:   if (flush_cnt_q == 4'(FLUSH_CYC - 1)) state_n = HANDLER;
            HANDLER: if (ins_eret) state_n = RETURN;
            RETURN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        exc_signal_n  = 2'b00;
        redirect_n    = 1'b0;
        redirect_pc_n = 32'h0;
        pipe_flush_n  = 1'b0;
        in_handler_n  = 1'b0;
        case (state_n)
            RAISE: begin
                exc_signal_n  = 2'b10;
                redirect_n    = 1'b1;
                redirect_pc_n = EXC_VECTOR;
                pipe_flush_n  = 1'b1;
                in_handler_n  = 1'b1;
            end
            FLUSH: begin
                pipe_flush_n = 1'b1;
                in_handler_n = 1'b1;
            end
            HANDLER: in_handler_n = 1'b1;
            RETURN: begin
                exc_signal_n  = 2'b01;
                redirect_n    = 1'b1;
                redirect_pc_n = exc_pc;
                pipe_flush_n  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            flush_cnt_q <= 4'd1;
            pending_q   <= '0;
            int_req_q   <= '0;
            exc_signal  <= 2'b00;
            cause       <= 4'd0;
            exc_pc      <= 32'h0;
            redirect_pc <= 32'h0;
            redirect    <= 1'b0;
            pipe_flush  <= 1'b0;
            in_handler  <= 1'b0;
            int_ack     <= '0;
            dropped_cnt <= 8'd0;
        end else begin
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 4'd1 : 4'd1;
            int_req_q   <= int_req;
            pending_q   <= (pending_q & ~ack_n) | int_rise;
            exc_signal  <= exc_signal_n;
            redirect    <= redirect_n;
            redirect_pc <= redirect_pc_n;
            pipe_flush  <= pipe_flush_n;
            in_handler  <= in_handler_n;
            int_ack     <= ack_n;
            if (take) begin
                cause  <= code_n;
                exc_pc <= pc_cur;
            end
            if (state_q == HANDLER && trap_qual && dropped_cnt != 8'd255)
                dropped_cnt <= dropped_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Directed self-checking bench for exc_request_ctrl (INT_W=4, FLUSH_CYC=2).
module tb_exc_request_ctrl;
    logic        clock_in = 1'b0;
    logic        reset = 1'b1;
    logic        ins_syscall = 1'b0, ins_break = 1'b0, ins_teq = 1'b0, teq_equal = 1'b0, ins_eret = 1'b0;
    logic [3:0]  int_req = 4'b0;
    logic [31:0] status = 32'h0000000f, pc_cur = 32'h0;
    logic [1:0]  exc_signal;
    logic [3:0]  cause;
    logic [31:0] exc_pc, redirect_pc;
    logic        redirect, pipe_flush, in_handler;
    logic [3:0]  int_ack;
    logic [7:0]  dropped_cnt;
    int          n_checks = 0, n_errors = 0;

    exc_request_ctrl #(.INT_W(4), .FLUSH_CYC(2), .EXC_VECTOR(32'h00400004)) dut (
        .clock_in(clock_in), .reset(reset), .ins_syscall(ins_syscall), .ins_break(ins_break),
        .ins_teq(ins_teq), .teq_equal(teq_equal), .ins_eret(ins_eret), .int_req(int_req),
        .status(status), .pc_cur(pc_cur), .exc_signal(exc_signal), .cause(cause),
        .exc_pc(exc_pc), .redirect_pc(redirect_pc), .redirect(redirect), .pipe_flush(pipe_flush),
        .in_handler(in_handler), .int_ack(int_ack), .dropped_cnt(dropped_cnt)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    // From RAISE: walk through FLUSH and HANDLER, issue eret, end in IDLE.
    task automatic finish_handler();
        tick();
        tick();
        ins_eret = 1'b1;
        tick();
        ins_eret = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (exc_signal !== 2'b00) begin n_errors++; $display("FAIL rst_exc: got %b exp 00", exc_signal); end
        n_checks++; if (cause !== 4'd0 || exc_pc !== 32'h0 || redirect_pc !== 32'h0) begin n_errors++; $display("FAIL rst_regs: cause %0d exc_pc %h redirect_pc %h exp all 0", cause, exc_pc, redirect_pc); end
        n_checks++; if ({redirect, pipe_flush, in_handler} !== 3'b000 || int_ack !== 4'b0 || dropped_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_flags: got %b %b %0d exp 000 0000 0", {redirect, pipe_flush, in_handler}, int_ack, dropped_cnt); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_syscall_eret();
        status = 32'h0000000f;
        pc_cur = 32'h00400100;
        ins_syscall = 1'b1;
        tick();
        ins_syscall = 1'b0;
        pc_cur = 32'h00400104;
        n_checks++; if (exc_signal !== 2'b10) begin n_errors++; $display("FAIL sys_exc: got %b exp 10", exc_signal); end
        n_checks++; if (cause !== 4'd8) begin n_errors++; $display("FAIL sys_cause: got %0d exp 8", cause); end
        n_checks++; if (exc_pc !== 32'h00400100) begin n_errors++; $display("FAIL sys_epc: got %h exp 00400100", exc_pc); end
        n_checks++; if (redirect_pc !== 32'h00400004 || redirect !== 1'b1) begin n_errors++; $display("FAIL sys_redir: got %h/%b exp 00400004/1", redirect_pc, redirect); end
        n_checks++; if (pipe_flush !== 1'b1 || in_handler !== 1'b1 || int_ack !== 4'b0) begin n_errors++; $display("FAIL sys_flags: flush %b inh %b ack %b exp 1 1 0000", pipe_flush, in_handler, int_ack); end
        tick();
        n_checks++; if (exc_signal !== 2'b00 || pipe_flush !== 1'b1 || redirect !== 1'b0 || in_handler !== 1'b1) begin n_errors++; $display("FAIL sys_flush: exc %b flush %b redir %b inh %b exp 00 1 0 1", exc_signal, pipe_flush, redirect, in_handler); end
        tick();
        n_checks++; if (pipe_flush !== 1'b0 || in_handler !== 1'b1) begin n_errors++; $display("FAIL sys_handler: flush %b inh %b exp 0 1", pipe_flush, in_handler); end
        ins_eret = 1'b1;
        tick();
        ins_eret = 1'b0;
        n_checks++; if (exc_signal !== 2'b01) begin n_errors++; $display("FAIL eret_exc: got %b exp 01", exc_signal); end
        n_checks++; if (redirect_pc !== 32'h00400100 || redirect !== 1'b1 || pipe_flush !== 1'b1 || in_handler !== 1'b0) begin n_errors++; $display("FAIL eret_redir: pc %h redir %b flush %b inh %b exp 00400100 1 1 0", redirect_pc, redirect, pipe_flush, in_handler); end
        tick();
        n_checks++; if (exc_signal !== 2'b00 || in_handler !== 1'b0 || redirect !== 1'b0 || pipe_flush !== 1'b0) begin n_errors++; $display("FAIL eret_idle: exc %b inh %b redir %b flush %b exp 00 0 0 0", exc_signal, in_handler, redirect, pipe_flush); end
        n_checks++; if (cause !== 4'd8 || exc_pc !== 32'h00400100) begin n_errors++; $display("FAIL hold: cause %0d epc %h exp 8 00400100", cause, exc_pc); end
        ins_eret = 1'b1;
        tick();
        ins_eret = 1'b0;
        n_checks++; if (exc_signal !== 2'b00) begin n_errors++; $display("FAIL idle_eret: got %b exp 00", exc_signal); end
    endtask

    task automatic test_teq();
        status = 32'h0000000f;
        pc_cur = 32'h00400200;
        ins_teq = 1'b1;
        teq_equal = 1'b0;
        tick();
        n_checks++; if (exc_signal !== 2'b00 || in_handler !== 1'b0) begin n_errors++; $display("FAIL teq_ne: exc %b inh %b exp 00 0", exc_signal, in_handler); end
        teq_equal = 1'b1;
        status = 32'h00000007;
        tick();
        n_checks++; if (exc_signal !== 2'b00 || in_handler !== 1'b0) begin n_errors++; $display("FAIL teq_mask: exc %b inh %b exp 00 0", exc_signal, in_handler); end
        status = 32'h0000000f;
        tick();
        ins_teq = 1'b0;
        teq_equal = 1'b0;
        n_checks++; if (exc_signal !== 2'b10 || cause !== 4'd13 || exc_pc !== 32'h00400200) begin n_errors++; $display("FAIL teq_take: exc %b cause %0d epc %h exp 10 13 00400200", exc_signal, cause, exc_pc); end
        finish_handler();
    endtask

    task automatic test_break_int();
        status = 32'h0000001f;
        pc_cur = 32'h00400300;
        ins_break = 1'b1;
        int_req = 4'b0110;
        tick();
        ins_break = 1'b0;
        pc_cur = 32'h00400400;
        n_checks++; if (exc_signal !== 2'b10 || cause !== 4'd9 || int_ack !== 4'b0000) begin n_errors++; $display("FAIL brk_take: exc %b cause %0d ack %b exp 10 9 0000", exc_signal, cause, int_ack); end
        tick();
        tick();
        n_checks++; if (in_handler !== 1'b1 || exc_signal !== 2'b00) begin n_errors++; $display("FAIL brk_hold_int: inh %b exc %b exp 1 00", in_handler, exc_signal); end
        ins_eret = 1'b1;
        tick();
        ins_eret = 1'b0;
        tick();
        n_checks++; if (exc_signal !== 2'b00) begin n_errors++; $display("FAIL int1_gap: got %b exp 00", exc_signal); end
        tick();
        n_checks++; if (exc_signal !== 2'b10 || cause !== 4'd0 || int_ack !== 4'b0010 || exc_pc !== 32'h00400400) begin n_errors++; $display("FAIL int1_take: exc %b cause %0d ack %b epc %h exp 10 0 0010 00400400", exc_signal, cause, int_ack, exc_pc); end
        tick();
        n_checks++; if (int_ack !== 4'b0000) begin n_errors++; $display("FAIL int1_ack_pulse: got %b exp 0000", int_ack); end
        tick();
        ins_eret = 1'b1;
        tick();
        ins_eret = 1'b0;
        tick();
        tick();
        n_checks++; if (exc_signal !== 2'b10 || cause !== 4'd0 || int_ack !== 4'b0100) begin n_errors++; $display("FAIL int2_take: exc %b cause %0d ack %b exp 10 0 0100", exc_signal, cause, int_ack); end
        finish_handler();
        tick();
        n_checks++; if (exc_signal !== 2'b00 || in_handler !== 1'b0) begin n_errors++; $display("FAIL int_drained: exc %b inh %b exp 00 0", exc_signal, in_handler); end
        int_req = 4'b0000;
        status = 32'h0000000f;
    endtask

    task automatic test_dropped();
        int bad_exc = 0;
        ins_syscall = 1'b1;
        tick();
        tick();
        tick();
        n_checks++; if (dropped_cnt !== 8'd0 || in_handler !== 1'b1) begin n_errors++; $display("FAIL drop_start: cnt %0d inh %b exp 0 1", dropped_cnt, in_handler); end
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (exc_signal !== 2'b00) bad_exc++;
            if (i == 100) begin
                n_checks++; if (dropped_cnt !== 8'd100) begin n_errors++; $display("FAIL drop_mid: got %0d exp 100", dropped_cnt); end
            end
        end
        n_checks++; if (dropped_cnt !== 8'd255) begin n_errors++; $display("FAIL drop_sat: got %0d exp 255", dropped_cnt); end
        n_checks++; if (bad_exc != 0 || in_handler !== 1'b1) begin n_errors++; $display("FAIL drop_quiet: strobes %0d inh %b exp 0 1", bad_exc, in_handler); end
        ins_syscall = 1'b0;
        ins_eret = 1'b1;
        tick();
        ins_eret = 1'b0;
        tick();
    endtask

    task automatic test_reset_flush();
        status = 32'h0000000f;
        int_req = 4'b0001;
        ins_syscall = 1'b1;
        tick();
        ins_syscall = 1'b0;
        tick();
        n_checks++; if (pipe_flush !== 1'b1 || exc_signal !== 2'b00 || dropped_cnt !== 8'd255) begin n_errors++; $display("FAIL rf_flush: flush %b exc %b cnt %0d exp 1 00 255", pipe_flush, exc_signal, dropped_cnt); end
        reset = 1'b1;
        int_req = 4'b0000;
        tick();
        n_checks++; if ({exc_signal, redirect, pipe_flush, in_handler} !== 5'b0 || int_ack !== 4'b0 || dropped_cnt !== 8'd0 || cause !== 4'd0 || exc_pc !== 32'h0 || redirect_pc !== 32'h0) begin n_errors++; $display("FAIL rf_reset: exc %b flags %b ack %b cnt %0d cause %0d epc %h rpc %h exp all 0", exc_signal, {redirect, pipe_flush, in_handler}, int_ack, dropped_cnt, cause, exc_pc, redirect_pc); end
        reset = 1'b0;
        status = 32'h0000001f;
        tick();
        tick();
        tick();
        n_checks++; if (exc_signal !== 2'b00 || in_handler !== 1'b0) begin n_errors++; $display("FAIL rf_pending_clr: exc %b inh %b exp 00 0", exc_signal, in_handler); end
    endtask

    initial begin
        test_reset();
        test_syscall_eret();
        test_teq();
        test_break_int();
        test_dropped();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
